sound_scheduler: RTL

//  Shares the single piezo buzzer between four game sound events (game over, player hit,

---
 rtl/sound_scheduler.sv | 113 +++++++++++
 1 files changed

// File: rtl/sound_scheduler.sv
// sound_scheduler: latches four sound-event requests and plays the highest-priority 3-note tune on buzz.
// Optional `SOUND_PREEMPT_EN lets a higher-priority pending event abort the tune that is playing.
module sound_scheduler #(
  parameter int CLK_HZ = 100_000_000,
  parameter int NOTE_CYCLES = 800_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic       buzz,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       grant,
  output logic [3:0] pending
);
  localparam int DW = $clog2(NOTE_CYCLES);
  localparam int TW = $clog2(CLK_HZ / 220 / 2 + 1);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic [DW-1:0] dur_cnt, dur_n;
  logic [TW-1:0] tone_cnt, tone_n;
  logic [1:0] note_idx, note_n, active_n, win;
  logic [3:0] clear;
  logic buzz_n, busy_n, grant_n, preempt, start, last;
  int div;
  // Half-period divisor per {id, note}; 0 marks a rest.
  function automatic int dv(input logic [3:0] i);
    case (i)
      4'h0: return CLK_HZ / 392 / 2;
      4'h1: return CLK_HZ / 330 / 2;
      4'h2: return CLK_HZ / 262 / 2;
      4'h4: return CLK_HZ / 220 / 2;
      4'h6: return CLK_HZ / 220 / 2;
      4'h8: return CLK_HZ / 523 / 2;
      4'h9: return CLK_HZ / 466 / 2;
      4'hA: return CLK_HZ / 392 / 2;
      4'hC: return CLK_HZ / 880 / 2;
      4'hD: return CLK_HZ / 784 / 2;
      default: return 0;
    endcase
  endfunction
`ifdef SOUND_PREEMPT_EN
  assign preempt = state == PLAY && |(pending & ((4'b1 << active_id) - 4'b1));
`else
  assign preempt = 1'b0;
`endif
  always_comb begin
    win = pending[0] ? 2'd0 : pending[1] ? 2'd1 : pending[2] ? 2'd2 : 2'd3;
    div = dv({active_id, note_idx});
    last = dur_cnt == DW'(NOTE_CYCLES - 1);
    start = (state == IDLE && |pending) || preempt;
    state_n = state;
    active_n = active_id;
    note_n = note_idx;
    dur_n = dur_cnt;
    tone_n = tone_cnt;
    buzz_n = buzz;
    busy_n = busy;
    grant_n = 1'b0;
    clear = '0;
    if (start) begin
      state_n = PLAY;
      active_n = win;
      clear = 4'b1 << win;
      note_n = '0;
      dur_n = '0;
      tone_n = '0;
      buzz_n = 1'b0;
      busy_n = 1'b1;
      grant_n = 1'b1;
    end else if (state == PLAY) begin
      dur_n = last ? '0 : dur_cnt + DW'(1);
      if (last) begin
        note_n = note_idx + 2'd1;
        tone_n = '0;
        buzz_n = 1'b0;
        state_n = note_idx == 2'd2 ? IDLE : PLAY;
        busy_n = note_idx != 2'd2;
      end else if (div == 0) begin
        tone_n = '0;
        buzz_n = 1'b0;
      end else if (int'(tone_cnt) == div - 1) begin
        tone_n = '0;
        buzz_n = ~buzz;
      end else begin
        tone_n = tone_cnt + TW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      active_id <= '0;
      note_idx <= '0;
      dur_cnt <= '0;
      tone_cnt <= '0;
      buzz <= 1'b0;
      busy <= 1'b0;
      grant <= 1'b0;
      pending <= '0;
    end else begin
      state <= state_n;
      active_id <= active_n;
      note_idx <= note_n;
      dur_cnt <= dur_n;
      tone_cnt <= tone_n;
      buzz <= buzz_n;
      busy <= busy_n;
      grant <= grant_n;
      pending <= (pending & ~clear) | req;
    end
  end
endmodule
